// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - one master's request/response bus into the SRAM arbiter
interface sram_arbiter_if #(
  parameter int ADDRBIT = 16,
  parameter int DATABIT = 32
);
  logic                   req;
  logic                   wen;
  logic [ADDRBIT-1:0]     addr;
  logic [DATABIT-1:0]     wdata;
  logic [DATABIT/8-1:0]   byte_en;
  logic                   ready;
  logic [DATABIT-1:0]     rdata;

  modport master (output req, wen, addr, wdata, byte_en, input ready, rdata);
  modport slave  (input req, wen, addr, wdata, byte_en, output ready, rdata);
endinterface

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - round-robin two-master arbiter and sequencer for the single-port SOC RAM
module sram_arbiter #(
  parameter int ADDRBIT     = 16,
  parameter int DATABIT     = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  sram_arbiter_if.slave        m0,
  sram_arbiter_if.slave        m1,
  output logic [ADDRBIT-1:0]   ram_addr,
  output logic [DATABIT-1:0]   ram_wdata,
  output logic                 ram_wen,
  output logic [DATABIT/8-1:0] ram_byte_en,
  input  logic [DATABIT-1:0]   ram_rdata
);
  localparam int BEBIT = DATABIT / 8;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  state_t             state_next;
  logic               sel;
  logic               last_gnt;
  logic               wen_q;
  logic [ADDRBIT-1:0] addr_q;
  logic [DATABIT-1:0] wdata_q;
  logic [BEBIT-1:0]   be_q;
  logic [DATABIT-1:0] rdata_q;
  logic [3:0]         wait_cnt;
  logic               gnt_any;
  logic               gnt_sel;
  logic               last_cycle;

  // Next-state logic and round-robin grant decision; a tie goes to the master that did not win last.
  always_comb begin
    state_next = state;
    gnt_any    = 1'b0;
    gnt_sel    = 1'b0;
    last_cycle = (state == BUSY) && (wait_cnt == WS);
    case (state)
      IDLE: begin
        if (m0.req && m1.req) begin
          gnt_any = 1'b1;
          gnt_sel = ~last_gnt;
        end else if (m0.req) begin
          gnt_any = 1'b1;
          gnt_sel = 1'b0;
        end else if (m1.req) begin
          gnt_any = 1'b1;
          gnt_sel = 1'b1;
        end
        if (gnt_any) state_next = BUSY;
      end
      BUSY:    if (last_cycle) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; reset lands in IDLE so ram_wen falls the moment rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Command latch, wait counter, read capture and grant history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel      <= 1'b0;
      last_gnt <= 1'b1;
      wen_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      rdata_q  <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            sel      <= gnt_sel;
            wen_q    <= gnt_sel ? m1.wen     : m0.wen;
            addr_q   <= gnt_sel ? m1.addr    : m0.addr;
            wdata_q  <= gnt_sel ? m1.wdata   : m0.wdata;
            be_q     <= gnt_sel ? m1.byte_en : m0.byte_en;
            wait_cnt <= '0;
          end
        end
        BUSY: begin
          if (wait_cnt != WS) wait_cnt <= wait_cnt + 4'd1;
          if (last_cycle && !wen_q) rdata_q <= ram_rdata;
        end
        DONE:    last_gnt <= sel;
        default: ;
      endcase
    end
  end

  // RAM drive during BUSY only; the write strobe fires in the final BUSY cycle so each access writes once.
  always_comb begin
    ram_addr    = '0;
    ram_wdata   = '0;
    ram_byte_en = '0;
    ram_wen     = 1'b0;
    if (state == BUSY) begin
      ram_addr    = addr_q;
      ram_wdata   = wdata_q;
      ram_byte_en = be_q;
      ram_wen     = wen_q & last_cycle;
    end
  end

  // Completion pulse and read data steered to the selected master; writes return zero data.
  always_comb begin
    m0.ready = (state == DONE) && !sel;
    m1.ready = (state == DONE) && sel;
    m0.rdata = (m0.ready && !wen_q) ? rdata_q : '0;
    m1.rdata = (m1.ready && !wen_q) ? rdata_q : '0;
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench for sram_arbiter with a scoreboard of expected completions
module tb_sram_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_arbiter_if bus0 ();
  sram_arbiter_if bus1 ();
  sram_arbiter_if wbus0 ();
  sram_arbiter_if wbus1 ();

  logic [15:0] ram_addr, wram_addr;
  logic [31:0] ram_wdata, ram_rdata, wram_wdata, wram_rdata;
  logic        ram_wen, wram_wen;
  logic [3:0]  ram_byte_en, wram_byte_en;

  logic [31:0] mem  [0:255];
  logic [31:0] wmem [0:255];
  logic        poke_en;
  logic [7:0]  poke_addr;
  logic [31:0] poke_data;

  sram_arbiter #(.WAIT_STATES(0)) dut (
    .clk(clk), .rst(rst), .m0(bus0), .m1(bus1),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wen(ram_wen),
    .ram_byte_en(ram_byte_en), .ram_rdata(ram_rdata)
  );

  sram_arbiter #(.WAIT_STATES(2)) dut_ws (
    .clk(clk), .rst(rst), .m0(wbus0), .m1(wbus1),
    .ram_addr(wram_addr), .ram_wdata(wram_wdata), .ram_wen(wram_wen),
    .ram_byte_en(wram_byte_en), .ram_rdata(wram_rdata)
  );

  assign ram_rdata  = mem[ram_addr[7:0]];
  assign wram_rdata = wmem[wram_addr[7:0]];

  always @(posedge clk) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    else if (ram_wen)
      for (int i = 0; i < 4; i++)
        if (ram_byte_en[i]) mem[ram_addr[7:0]][8*i +: 8] <= ram_wdata[8*i +: 8];
  end

  always @(posedge clk) begin
    if (poke_en) wmem[poke_addr] <= poke_data;
    else if (wram_wen)
      for (int i = 0; i < 4; i++)
        if (wram_byte_en[i]) wmem[wram_addr[7:0]][8*i +: 8] <= wram_wdata[8*i +: 8];
  end

  typedef struct {
    int          m;
    logic [31:0] d;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic run_access(input int m, input logic wen, input logic [15:0] a,
                            input logic [31:0] wd, input logic [3:0] be,
                            output int who, output logic [31:0] rd, output int lat);
    @(negedge clk);
    if (m == 0) begin
      bus0.req = 1'b1; bus0.wen = wen; bus0.addr = a; bus0.wdata = wd; bus0.byte_en = be;
    end else begin
      bus1.req = 1'b1; bus1.wen = wen; bus1.addr = a; bus1.wdata = wd; bus1.byte_en = be;
    end
    who = -1; rd = '0; lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus0.ready || bus1.ready) begin
        who = bus0.ready ? 0 : 1;
        rd  = bus0.ready ? bus0.rdata : bus1.rdata;
        lat = i;
        break;
      end
    end
    bus0.req = 1'b0; bus1.req = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    int   who;
    logic [31:0] rd;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({ram_addr, ram_wdata, ram_wen, ram_byte_en, bus0.ready, bus1.ready, bus0.rdata, bus1.rdata} !== '0) begin
      n_err++; $display("FAIL reset_outputs: got addr=%h wdata=%h wen=%b be=%h rdy=%b%b, required all 0",
                        ram_addr, ram_wdata, ram_wen, ram_byte_en, bus0.ready, bus1.ready);
    end
    rst = 1'b0;
    poke(8'h30, 32'h5555_5555);
    poke(8'h40, 32'h4040_4040);
    poke(8'h41, 32'h4141_4141);
    @(negedge clk);
    bus0.req = 1'b1; bus0.wen = 1'b1; bus0.addr = 16'h0030; bus0.wdata = 32'hFFFF_FFFF; bus0.byte_en = 4'hF;
    @(negedge clk);
    n_cmp++;
    if (ram_wen !== 1'b1) begin
      n_err++; $display("FAIL busy_write_wen: got %b, required 1", ram_wen);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({ram_wen, bus0.ready, bus1.ready} !== 3'b000) begin
      n_err++; $display("FAIL reset_mid_write: got wen=%b rdy=%b%b, required 000", ram_wen, bus0.ready, bus1.ready);
    end
    @(negedge clk);
    rst = 1'b0; bus0.req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (mem[8'h30] !== 32'h5555_5555) begin
      n_err++; $display("FAIL reset_no_write: got %h, required 55555555", mem[8'h30]);
    end
    sb.push_back('{0, 32'h4040_4040, 2});
    sb.push_back('{1, 32'h4141_4141, 3});
    bus0.req = 1'b1; bus0.wen = 1'b0; bus0.addr = 16'h0040;
    bus1.req = 1'b1; bus1.wen = 1'b0; bus1.addr = 16'h0041;
    for (int k = 0; k < 2; k++) begin
      who = -1; rd = '0;
      for (int i = 1; i <= 20; i++) begin
        @(negedge clk);
        if (bus0.ready || bus1.ready) begin
          who = bus0.ready ? 0 : 1;
          rd  = bus0.ready ? bus0.rdata : bus1.rdata;
          if (bus0.ready) bus0.req = 1'b0;
          if (bus1.ready) bus1.req = 1'b0;
          break;
        end
      end
      e = sb.pop_front();
      n_cmp++;
      if (who !== e.m || rd !== e.d) begin
        n_err++; $display("FAIL post_reset_grant%0d: got m%0d data %h, required m%0d data %h", k, who, rd, e.m, e.d);
      end
    end
    bus0.req = 1'b0; bus1.req = 1'b0;
  endtask

  task automatic test_write_read();
    exp_t e;
    int   who, lat;
    logic [31:0] rd;
    sb.push_back('{0, 32'h0, 2});
    run_access(0, 1'b1, 16'h0010, 32'hDEAD_BEEF, 4'hF, who, rd, lat);
    e = sb.pop_front();
    n_cmp++;
    if (who !== e.m || rd !== e.d || lat !== e.lat) begin
      n_err++; $display("FAIL m0_write: got m%0d data %h lat %0d, required m%0d data %h lat %0d", who, rd, lat, e.m, e.d, e.lat);
    end
    sb.push_back('{0, 32'hDEAD_BEEF, 2});
    run_access(0, 1'b0, 16'h0010, 32'h0, 4'h0, who, rd, lat);
    e = sb.pop_front();
    n_cmp++;
    if (who !== e.m || rd !== e.d || lat !== e.lat) begin
      n_err++; $display("FAIL m0_readback: got m%0d data %h lat %0d, required m%0d data %h lat %0d", who, rd, lat, e.m, e.d, e.lat);
    end
  endtask

  task automatic test_byte_write();
    exp_t e;
    int   who, lat;
    logic [31:0] rd;
    poke(8'h24, 32'h1122_3344);
    sb.push_back('{1, 32'h0, 2});
    run_access(1, 1'b1, 16'h0024, 32'hAABB_CCDD, 4'b0101, who, rd, lat);
    e = sb.pop_front();
    n_cmp++;
    if (who !== e.m || rd !== e.d || lat !== e.lat) begin
      n_err++; $display("FAIL m1_byte_write: got m%0d data %h lat %0d, required m%0d data %h lat %0d", who, rd, lat, e.m, e.d, e.lat);
    end
    sb.push_back('{1, 32'h11BB_33DD, 2});
    run_access(1, 1'b0, 16'h0024, 32'h0, 4'h0, who, rd, lat);
    e = sb.pop_front();
    n_cmp++;
    if (who !== e.m || rd !== e.d || lat !== e.lat) begin
      n_err++; $display("FAIL m1_byte_read: got m%0d data %h lat %0d, required m%0d data %h lat %0d", who, rd, lat, e.m, e.d, e.lat);
    end
  endtask

  task automatic test_contention();
    exp_t e;
    int   n = 0;
    int   prev = 0;
    int   who;
    logic [31:0] rd;
    poke(8'h20, 32'hA0A0_A0A0);
    poke(8'h21, 32'hB1B1_B1B1);
    for (int k = 0; k < 6; k++)
      sb.push_back('{k % 2, (k % 2 == 0) ? 32'hA0A0_A0A0 : 32'hB1B1_B1B1, 3});
    @(negedge clk);
    bus0.req = 1'b1; bus0.wen = 1'b0; bus0.addr = 16'h0020;
    bus1.req = 1'b1; bus1.wen = 1'b0; bus1.addr = 16'h0021;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus0.ready && bus1.ready) begin
        n_cmp++; n_err++;
        $display("FAIL contention_dual_ready: got both ready at step %0d, required one", i);
      end
      if (bus0.ready || bus1.ready) begin
        who = bus0.ready ? 0 : 1;
        rd  = bus0.ready ? bus0.rdata : bus1.rdata;
        e = sb.pop_front();
        n_cmp++;
        if (who !== e.m || rd !== e.d) begin
          n_err++; $display("FAIL contention_grant%0d: got m%0d data %h, required m%0d data %h", n, who, rd, e.m, e.d);
        end
        if (prev > 0) begin
          n_cmp++;
          if (i - prev !== e.lat) begin
            n_err++; $display("FAIL contention_spacing%0d: got %0d cycles, required %0d", n, i - prev, e.lat);
          end
        end
        prev = i;
        n++;
        if (n == 6) begin
          bus0.req = 1'b0; bus1.req = 1'b0;
          break;
        end
      end
    end
    bus0.req = 1'b0; bus1.req = 1'b0;
    n_cmp++;
    if (n !== 6) begin
      n_err++; $display("FAIL contention_count: got %0d completions, required 6", n);
      sb.delete();
    end
  endtask

  task automatic test_wait_states();
    exp_t e;
    int   lat = 0;
    int   addr_cnt = 0;
    logic wen_seen = 1'b0;
    logic other_rdy = 1'b0;
    logic [31:0] rd = '0;
    poke(8'h04, 32'h0BAD_F00D);
    sb.push_back('{0, 32'h0BAD_F00D, 4});
    @(negedge clk);
    wbus0.req = 1'b1; wbus0.wen = 1'b0; wbus0.addr = 16'h0004; wbus0.wdata = 32'h0; wbus0.byte_en = 4'h0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (wram_wen) wen_seen = 1'b1;
      if (wram_addr == 16'h0004) addr_cnt++;
      if (wbus0.ready || wbus1.ready) begin
        lat = i; rd = wbus0.rdata; other_rdy = wbus1.ready;
        break;
      end
    end
    wbus0.req = 1'b0;
    e = sb.pop_front();
    n_cmp++;
    if (lat !== e.lat || rd !== e.d || other_rdy !== 1'b0) begin
      n_err++; $display("FAIL ws2_read: got lat %0d data %h m1rdy %b, required lat %0d data %h m1rdy 0", lat, rd, other_rdy, e.lat, e.d);
    end
    n_cmp++;
    if (addr_cnt !== 3) begin
      n_err++; $display("FAIL ws2_addr_hold: got %0d cycles, required 3", addr_cnt);
    end
    n_cmp++;
    if (wen_seen !== 1'b0) begin
      n_err++; $display("FAIL ws2_no_write: got ram_wen seen %b, required 0", wen_seen);
    end
  endtask

  task automatic test_drop_req();
    exp_t e;
    int   pulses = 0;
    logic [31:0] rd = '0;
    poke(8'h50, 32'hCAFE_F00D);
    poke(8'h60, 32'h1234_5678);
    sb.push_back('{1, 32'hCAFE_F00D, 0});
    @(negedge clk);
    bus1.req = 1'b1; bus1.wen = 1'b0; bus1.addr = 16'h0050;
    @(negedge clk);
    bus1.addr = 16'h0060; bus1.req = 1'b0;
    #1;
    n_cmp++;
    if (ram_addr !== 16'h0050) begin
      n_err++; $display("FAIL drop_latched_addr: got %h, required 0050", ram_addr);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus1.ready) begin
        pulses++; rd = bus1.rdata;
      end
    end
    e = sb.pop_front();
    n_cmp++;
    if (pulses !== 1 || rd !== e.d) begin
      n_err++; $display("FAIL drop_complete: got %0d pulses data %h, required 1 pulse data %h", pulses, rd, e.d);
    end
  endtask

  initial begin
    rst = 1'b1;
    poke_en = 1'b0; poke_addr = '0; poke_data = '0;
    bus0.req = 1'b0; bus0.wen = 1'b0; bus0.addr = '0; bus0.wdata = '0; bus0.byte_en = '0;
    bus1.req = 1'b0; bus1.wen = 1'b0; bus1.addr = '0; bus1.wdata = '0; bus1.byte_en = '0;
    wbus0.req = 1'b0; wbus0.wen = 1'b0; wbus0.addr = '0; wbus0.wdata = '0; wbus0.byte_en = '0;
    wbus1.req = 1'b0; wbus1.wen = 1'b0; wbus1.addr = '0; wbus1.wdata = '0; wbus1.byte_en = '0;
    test_reset();
    test_write_read();
    test_byte_write();
    test_contention();
    test_wait_states();
    test_drop_req();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
